ifetch_decode: RTL and testbench

Instruction fetch and decode front end for the 16-bit minesweeper core. It drives the byte address into the instruction ROM, registers the returned 16-bit word, and slices it into decoded fields for the execute stage. It resolves JUMP at fetch with no bubble and predicts branches not-taken. Redirects on a taken branch reported by execute, and freezes on HALT.

---
 rtl/ifetch_decode.sv | 123 ++++++++++++
 tb/tb_ifetch_decode.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_decode.sv
// ifetch_decode: instruction fetch and decode front end for the 16-bit
// minesweeper core. Drives the ROM byte address, registers the returned
// word and slices it into decoded fields for execute. JUMP resolves at
// fetch with no bubble; branches are predicted not-taken and redirected
// when execute reports them taken. HALT freezes fetch until reset.
//
// state   | meaning
// --------+------------------------------------------------------------
// BOOT    | one cycle after reset while ROM output settles; no latch
// RUN     | normal fetch / redirect / stall handling
// HALT    | HALT word was latched; fetch frozen, only reset exits

module ifetch_decode #(
   parameter logic [8:0] RESET_PC = 9'd0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_taken,
   input  logic [15:0] i_q,
   output logic [9:0]  o_addr,
   output logic        o_ir_valid,
   output logic [9:0]  o_pc_out,
   output logic [3:0]  o_opcode,
   output logic [2:0]  o_rs,
   output logic [2:0]  o_rt,
   output logic [2:0]  o_rd,
   output logic [2:0]  o_funct,
   output logic [15:0] o_imm,
   output logic        o_halted
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [3:0] OP_HALT = 4'b0000;
   localparam logic [3:0] OP_JUMP = 4'b0001;

   logic [1:0]  r_state;
   logic [8:0]  r_pc;
   logic [15:0] r_ir;
   logic [8:0]  r_ir_pc;
   logic        r_ir_valid;
   logic        r_halted;

   logic        w_is_branch;
   logic        w_redirect;
   logic [8:0]  w_target;
   logic [3:0]  w_q_op;

   // Branch opcodes are 10xx; TAKEN only matters for a live branch in IR.
   always_comb begin
      w_is_branch = r_ir_valid && (r_ir[15:14] == 2'b10);
      w_redirect  = i_taken && w_is_branch;
      w_target    = r_ir_pc + 9'd1 + {{3{r_ir[5]}}, r_ir[5:0]};
      w_q_op      = i_q[15:12];
   end

   // Fetch/decode state machine; redirect outranks JUMP/HALT seen on Q.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_BOOT;
         r_pc       <= RESET_PC;
         r_ir       <= 16'd0;
         r_ir_pc    <= 9'd0;
         r_ir_valid <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         case (r_state)
            ST_BOOT: begin
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (!i_stall) begin
                  if (w_redirect) begin
                     r_pc       <= w_target;
                     r_ir_valid <= 1'b0;
                  end else begin
                     r_ir       <= i_q;
                     r_ir_pc    <= r_pc;
                     r_ir_valid <= 1'b1;
                     if (w_q_op == OP_JUMP) begin
                        r_pc <= i_q[8:0];
                     end else if (w_q_op == OP_HALT) begin
                        r_state <= ST_HALT;
                     end else begin
                        r_pc <= r_pc + 9'd1;
                     end
                  end
               end
            end
            ST_HALT: begin
               // HALT word stays visible one cycle, then valid drops as halted rises.
               r_ir_valid <= 1'b0;
               r_halted   <= 1'b1;
            end
            default: begin
               r_state <= ST_BOOT;
            end
         endcase
      end
   end

   // Decoded fields are plain slices of the instruction register.
   always_comb begin
      o_addr     = {r_pc, 1'b0};
      o_ir_valid = r_ir_valid;
      o_pc_out   = {r_ir_pc, 1'b0};
      o_opcode   = r_ir[15:12];
      o_rs       = r_ir[11:9];
      o_rt       = r_ir[8:6];
      o_rd       = r_ir[5:3];
      o_funct    = r_ir[2:0];
      o_halted   = r_halted;
      if (r_ir[15:12] == OP_JUMP) begin
         o_imm = {4'd0, r_ir[11:0]};
      end else begin
         o_imm = {{10{r_ir[5]}}, r_ir[5:0]};
      end
   end

endmodule

// File: tb/tb_ifetch_decode.sv
// Scoreboard bench for ifetch_decode: the stimulus pushes the expected
// instruction stream (word indices) into a queue, and a monitor pops and
// compares each newly latched instruction as the DUT presents it.

module tb_ifetch_decode;

   logic        clk;
   logic        i_reset;
   logic        i_stall;
   logic        i_taken;
   logic [15:0] i_q;
   logic [9:0]  o_addr;
   logic        o_ir_valid;
   logic [9:0]  o_pc_out;
   logic [3:0]  o_opcode;
   logic [2:0]  o_rs;
   logic [2:0]  o_rt;
   logic [2:0]  o_rd;
   logic [2:0]  o_funct;
   logic [15:0] o_imm;
   logic        o_halted;

   logic [15:0] rom [512];
   logic        take_set [512];
   logic [8:0]  exp_q [$];

   int          total = 0;
   int          bad = 0;
   int          pend = 0;
   logic [9:0]  pend_tgt = 10'd0;

   ifetch_decode #(.RESET_PC(9'd0)) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_stall    (i_stall),
      .i_taken    (i_taken),
      .i_q        (i_q),
      .o_addr     (o_addr),
      .o_ir_valid (o_ir_valid),
      .o_pc_out   (o_pc_out),
      .o_opcode   (o_opcode),
      .o_rs       (o_rs),
      .o_rt       (o_rt),
      .o_rd       (o_rd),
      .o_funct    (o_funct),
      .o_imm      (o_imm),
      .o_halted   (o_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign i_q = rom[o_addr[9:1]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_imm(input logic [15:0] w);
      if (w[15:12] == 4'b0001) return {4'd0, w[11:0]};
      return {{10{w[5]}}, w[5:0]};
   endfunction

   // Hand-computed branch targets (byte addresses) for the program's branches.
   function automatic logic [9:0] tgt_of(input logic [8:0] idx);
      case (idx)
         9'd3:    return 10'd10;
         9'd30:   return 10'd88;
         9'd101:  return 10'd230;
         9'd136:  return 10'd278;
         default: return 10'd0;
      endcase
   endfunction

   // Monitor: compare every newly latched instruction against the queue head.
   initial begin : monitor
      logic       m_stall;
      logic       m_rst;
      logic [8:0] idx;
      logic [15:0] w;
      forever begin
         @(posedge clk);
         m_stall = i_stall;
         m_rst   = i_reset;
         @(negedge clk);
         if (!m_rst && !m_stall && o_ir_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word_pc", {22'd0, o_pc_out}, 32'hFFFF_FFFF);
            end else begin
               idx = exp_q.pop_front();
               w   = rom[idx];
               chk("seq_pc_out", {22'd0, o_pc_out}, {22'd0, idx, 1'b0});
               chk("seq_fields", {16'd0, o_opcode, o_rs, o_rt, o_rd, o_funct}, {16'd0, w});
               chk("seq_imm", {16'd0, o_imm}, {16'd0, exp_imm(w)});
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic push_range(input int a, input int b);
      for (int i = a; i <= b; i++) exp_q.push_back(9'(i));
   endtask

   // One clock: check pending redirect bubble/target, then decide TAKEN.
   task automatic cycle();
      @(negedge clk);
      #1;
      if (pend == 2) begin
         chk("taken_bubble", {21'd0, o_ir_valid, o_addr}, {21'd0, 1'b0, pend_tgt});
         pend = 1;
      end else if (pend == 1) begin
         chk("taken_target", {21'd0, o_ir_valid, o_pc_out}, {21'd0, 1'b1, pend_tgt});
         pend = 0;
      end
      if (o_ir_valid && o_pc_out == 10'd88)
         chk("addi_imm_rt", {13'd0, o_imm, o_rt}, {13'd0, 16'hFFFF, 3'd6});
      if (o_ir_valid && take_set[o_pc_out[9:1]] && pend == 0) begin
         i_taken  = 1'b1;
         pend     = 2;
         pend_tgt = tgt_of(o_pc_out[9:1]);
      end else begin
         i_taken = 1'b0;
      end
   endtask

   task automatic drain(input string name, input int limit);
      int n = 0;
      while (exp_q.size() > 0 && n < limit) begin
         cycle();
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   task automatic reset_dut();
      i_reset = 1'b1;
      i_stall = 1'b0;
      i_taken = 1'b0;
      pend    = 0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("rst_addr_valid_halted", {20'd0, o_addr, o_ir_valid, o_halted}, 32'd0);
      chk("rst_pc_out_opcode", {18'd0, o_pc_out, o_opcode}, 32'd0);
      chk("rst_fields_imm", {4'd0, o_rs, o_rt, o_rd, o_funct, o_imm}, 32'd0);
      exp_q.delete();
      i_reset = 1'b0;
      @(negedge clk); #1;
      chk("boot_cycle", {21'd0, o_ir_valid, o_addr}, 32'd0);
   endtask

   task automatic clear_takes();
      for (int i = 0; i < 512; i++) take_set[i] = 1'b0;
   endtask

   initial begin : stim
      bit stalled;
      bit jump_seen;
      int n;
      i_reset = 1'b1;
      i_stall = 1'b0;
      i_taken = 1'b0;
      for (int i = 0; i < 512; i++) rom[i] = {4'hF, 9'(i + 1), 3'b000};
      rom[3]   = 16'h9001;   // BNE  +1  -> word 5
      rom[30]  = 16'h800D;   // BEQ  +13 -> word 44
      rom[33]  = 16'h1007;   // JUMP word 7
      rom[44]  = 16'h21BF;   // ADDI $6,$0,-1
      rom[101] = 16'h900D;   // BNE  +13 -> word 115
      rom[136] = 16'h8002;   // BEQ  +2  -> word 139
      rom[137] = 16'h0000;   // HALT
      clear_takes();

      // Phase 1: sequential fetch, not-taken branches, stall at word 20, JUMP at 33.
      reset_dut();
      push_range(0, 33);
      push_range(7, 8);
      cycle();
      chk("first_valid", {5'd0, o_ir_valid, o_pc_out, o_imm}, {5'd0, 1'b1, 10'd0, 16'h0008});
      stalled   = 0;
      jump_seen = 0;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         if (jump_seen) begin
            chk("jump_no_gap", {21'd0, o_ir_valid, o_pc_out}, {21'd0, 1'b1, 10'd14});
            jump_seen = 0;
         end
         if (o_ir_valid && o_pc_out == 10'd66) begin
            chk("jump_addr_same_cycle", {22'd0, o_addr}, 32'd14);
            chk("jump_imm", {16'd0, o_imm}, 32'h0007);
            jump_seen = 1;
         end
         if (o_ir_valid && o_pc_out == 10'd40 && !stalled) begin
            stalled = 1;
            i_stall = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk); #1;
               chk("stall_hold", {o_addr, o_pc_out, o_ir_valid, o_opcode, o_halted},
                   {10'd42, 10'd40, 1'b1, 4'hF, 1'b0});
               i_taken = (k == 1);
               if (k == 2) i_stall = 1'b0;
            end
            i_taken = 1'b0;
         end
         cycle();
         n++;
      end
      chk("phase1_drain", exp_q.size(), 0);

      // Phase 2: taken branches at 3, 30, 101, and 136 (branch over HALT).
      reset_dut();
      take_set[3] = 1'b1;
      take_set[30] = 1'b1;
      take_set[101] = 1'b1;
      take_set[136] = 1'b1;
      push_range(0, 3);
      push_range(5, 30);
      push_range(44, 101);
      push_range(115, 136);
      push_range(139, 140);
      drain("phase2_drain", 300);
      chk("branch_over_halt_no_halt", {31'd0, o_halted}, 32'd0);
      clear_takes();

      // Phase 3: reach the HALT word at 137 and verify the freeze.
      reset_dut();
      take_set[30] = 1'b1;
      push_range(0, 30);
      push_range(44, 137);
      drain("phase3_drain", 300);
      chk("halt_word_visible", {25'd0, o_ir_valid, o_opcode, o_halted, 1'b0},
          {25'd0, 1'b1, 4'h0, 1'b0, 1'b0});
      chk("halt_word_addr", {22'd0, o_addr}, 32'd274);
      @(negedge clk); #1;
      chk("halted_rise", {20'd0, o_halted, o_ir_valid, o_addr}, {20'd0, 1'b1, 1'b0, 10'd274});
      for (int k = 0; k < 22; k++) begin
         i_stall = 1'($urandom_range(0, 1));
         i_taken = 1'($urandom_range(0, 1));
         @(negedge clk); #1;
         chk("halt_frozen", {20'd0, o_halted, o_ir_valid, o_addr}, {20'd0, 1'b1, 1'b0, 10'd274});
      end
      clear_takes();
      reset_dut();
      push_range(0, 2);
      drain("restart_after_halt", 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
